label_readout: RTL and testbench

LABEL_READOUT -- requirements
Module: label_readout

---
 rtl/label_readout.sv | 228 ++++++++++++++++++++++
 tb/tb_label_readout.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/label_readout.sv
// Burst label readout: fetches 128-bit labels from the label store and
// streams them byte-wise to an SPI slave, preceded by zero padding.
module label_readout #(
    parameter int PAD_BYTES = 6,
    parameter int ADDR_W    = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [7:0]        count,
    output logic              fetch_req,
    output logic [ADDR_W-1:0] fetch_addr,
    input  logic              fetch_done,
    input  logic [127:0]      label_in,
    input  logic              out_next,
    output logic [7:0]        out_byte,
    output logic              busy,
    output logic              underrun
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH0,
        S_PAD,
        S_DATA,
        S_DONE
    } state_t;

    localparam logic [7:0] PAD_INIT = 8'(PAD_BYTES);

    state_t            state, state_n;
    logic [127:0]      act_buf, act_buf_n;
    logic [127:0]      spare_buf, spare_buf_n;
    logic              act_valid, act_valid_n;
    logic              spare_valid, spare_valid_n;
    logic [7:0]        pad_cnt, pad_cnt_n;
    logic [3:0]        idx, idx_n;
    logic [7:0]        remaining, remaining_n;
    logic [7:0]        issued, issued_n;
    logic [7:0]        total, total_n;
    logic              outstanding, outstanding_n;
    logic              fetch_req_n;
    logic [ADDR_W-1:0] fetch_addr_n;
    logic [7:0]        out_byte_n;
    logic              busy_n;
    logic              underrun_n;

    // A returning label fills the active slot when it is empty, else the spare.
    logic         fill;
    logic         fill_act;
    logic         fill_spare;
    logic         act_v_eff;
    logic         spare_v_eff;
    logic [127:0] act_eff;
    logic [127:0] spare_eff;

    always_comb begin
        fill        = fetch_done & outstanding;
        fill_act    = fill & ~act_valid;
        fill_spare  = fill & act_valid;
        act_v_eff   = act_valid | fill_act;
        spare_v_eff = spare_valid | fill_spare;
        act_eff     = fill_act ? label_in : act_buf;
        spare_eff   = fill_spare ? label_in : spare_buf;
    end

    always_comb begin
        state_n       = state;
        act_buf_n     = act_buf;
        spare_buf_n   = spare_buf;
        act_valid_n   = act_valid;
        spare_valid_n = spare_valid;
        pad_cnt_n     = pad_cnt;
        idx_n         = idx;
        remaining_n   = remaining;
        issued_n      = issued;
        total_n       = total;
        outstanding_n = outstanding;
        fetch_req_n   = 1'b0;
        fetch_addr_n  = fetch_addr;
        out_byte_n    = out_byte;
        busy_n        = busy;
        underrun_n    = underrun;

        if (start) begin
            // Start aborts everything in flight and wins over out_next.
            act_valid_n   = 1'b0;
            spare_valid_n = 1'b0;
            act_buf_n     = '0;
            spare_buf_n   = '0;
            idx_n         = '0;
            out_byte_n    = 8'h00;
            underrun_n    = 1'b0;
            total_n       = count;
            if (count == 8'd0) begin
                state_n       = S_DONE;
                busy_n        = 1'b0;
                outstanding_n = 1'b0;
                pad_cnt_n     = '0;
                remaining_n   = '0;
                issued_n      = '0;
            end else begin
                state_n       = S_FETCH0;
                busy_n        = 1'b1;
                fetch_req_n   = 1'b1;
                fetch_addr_n  = start_addr;
                outstanding_n = 1'b1;
                issued_n      = 8'd1;
                remaining_n   = count - 8'd1;
                pad_cnt_n     = PAD_INIT;
            end
        end else begin
            if (fill) begin
                outstanding_n = 1'b0;
                if (fill_act) begin
                    act_buf_n   = label_in;
                    act_valid_n = 1'b1;
                end else begin
                    spare_buf_n   = label_in;
                    spare_valid_n = 1'b1;
                end
            end

            unique case (state)
                S_IDLE, S_DONE: begin
                    if (out_next) begin
                        out_byte_n = 8'h00;
                    end
                end
                S_FETCH0, S_PAD: begin
                    if (state == S_FETCH0 && fill_act) begin
                        state_n = S_PAD;
                    end
                    if (out_next) begin
                        if (pad_cnt != 8'd0) begin
                            out_byte_n = 8'h00;
                            pad_cnt_n  = pad_cnt - 8'd1;
                        end else if (act_v_eff) begin
                            out_byte_n = act_eff[7:0];
                            idx_n      = 4'd1;
                            state_n    = S_DATA;
                        end else begin
                            out_byte_n = 8'h00;
                            underrun_n = 1'b1;
                        end
                    end
                end
                S_DATA: begin
                    // One prefetch per label, gated by the single-outstanding rule.
                    if (!outstanding && !spare_valid && issued < total) begin
                        fetch_req_n   = 1'b1;
                        fetch_addr_n  = fetch_addr + 1'b1;
                        outstanding_n = 1'b1;
                        issued_n      = issued + 8'd1;
                    end
                    if (out_next) begin
                        if (!act_v_eff) begin
                            out_byte_n = 8'h00;
                            underrun_n = 1'b1;
                        end else begin
                            out_byte_n = act_eff[{idx, 3'b000} +: 8];
                            idx_n      = idx + 4'd1;
                            if (idx == 4'd15) begin
                                if (remaining == 8'd0) begin
                                    state_n     = S_DONE;
                                    busy_n      = 1'b0;
                                    act_valid_n = 1'b0;
                                end else begin
                                    remaining_n = remaining - 8'd1;
                                    if (spare_v_eff) begin
                                        act_buf_n     = spare_eff;
                                        act_valid_n   = 1'b1;
                                        spare_valid_n = 1'b0;
                                    end else begin
                                        act_valid_n = 1'b0;
                                    end
                                end
                            end
                        end
                    end
                end
                default: begin
                    state_n = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            act_buf     <= '0;
            spare_buf   <= '0;
            act_valid   <= 1'b0;
            spare_valid <= 1'b0;
            pad_cnt     <= '0;
            idx         <= '0;
            remaining   <= '0;
            issued      <= '0;
            total       <= '0;
            outstanding <= 1'b0;
            fetch_req   <= 1'b0;
            fetch_addr  <= '0;
            out_byte    <= 8'h00;
            busy        <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            state       <= state_n;
            act_buf     <= act_buf_n;
            spare_buf   <= spare_buf_n;
            act_valid   <= act_valid_n;
            spare_valid <= spare_valid_n;
            pad_cnt     <= pad_cnt_n;
            idx         <= idx_n;
            remaining   <= remaining_n;
            issued      <= issued_n;
            total       <= total_n;
            outstanding <= outstanding_n;
            fetch_req   <= fetch_req_n;
            fetch_addr  <= fetch_addr_n;
            out_byte    <= out_byte_n;
            busy        <= busy_n;
            underrun    <= underrun_n;
        end
    end

endmodule

// File: tb/tb_label_readout.sv
// Directed self-checking bench for label_readout with an
// automatic label-store responder.
module tb_label_readout;

    logic         clk;
    logic         rst;
    logic         start;
    logic [12:0]  start_addr;
    logic [7:0]   count;
    logic         fetch_req;
    logic [12:0]  fetch_addr;
    logic         fetch_done;
    logic [127:0] label_in;
    logic         out_next;
    logic [7:0]   out_byte;
    logic         busy;
    logic         underrun;

    int n_tests = 0;
    int n_fail  = 0;

    logic        auto_fetch;
    int          fetch_lat;
    int          block_from;
    logic        release_fetch;
    int          req_cnt;
    logic [12:0] req_addr [0:15];

    label_readout #(.PAD_BYTES(6), .ADDR_W(13)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .start_addr (start_addr),
        .count      (count),
        .fetch_req  (fetch_req),
        .fetch_addr (fetch_addr),
        .fetch_done (fetch_done),
        .label_in   (label_in),
        .out_next   (out_next),
        .out_byte   (out_byte),
        .busy       (busy),
        .underrun   (underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Label for wire ID a: byte i = {a[3:0], i[3:0]}
    function automatic logic [127:0] mk_label(input logic [12:0] a);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) begin
            r[i*8 +: 8] = {a[3:0], 4'(i)};
        end
        return r;
    endfunction

    // Label-store model
    initial begin
        logic [12:0] a;
        int lat;
        forever begin
            @(negedge clk);
            if (fetch_req && auto_fetch) begin
                a = fetch_addr;
                if (req_cnt < 16) req_addr[req_cnt] = a;
                req_cnt++;
                lat = fetch_lat;
                if (req_cnt > block_from) begin
                    for (int k = 0; k < 4000 && !release_fetch; k++)
                        @(negedge clk);
                end
                repeat (lat) @(negedge clk);
                fetch_done = 1'b1;
                label_in   = mk_label(a);
                @(negedge clk);
                fetch_done = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "timeout");
    end

    task automatic do_reset();
        rst           = 1'b1;
        start         = 1'b0;
        out_next      = 1'b0;
        fetch_done    = 1'b0;
        auto_fetch    = 1'b1;
        fetch_lat     = 0;
        block_from    = 255;
        release_fetch = 1'b0;
        req_cnt       = 0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_start(input logic [12:0] a, input logic [7:0] c);
        start      = 1'b1;
        start_addr = a;
        count      = c;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic next_byte(output logic [7:0] b);
        out_next = 1'b1;
        @(negedge clk);
        out_next = 1'b0;
        b = out_byte;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        start      = 1'b0;
        start_addr = '0;
        count      = '0;
        out_next   = 1'b0;
        fetch_done = 1'b0;
        label_in   = '0;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({fetch_req, busy, underrun} !== 3'b000) begin
            $display("FAIL reset_flags: got %b want 000",
                     {fetch_req, busy, underrun});
            n_fail++;
        end
        n_tests++;
        if (out_byte !== 8'h00 || fetch_addr !== 13'h0) begin
            $display("FAIL reset_data: out_byte=%h fetch_addr=%h want 00/0000",
                     out_byte, fetch_addr);
            n_fail++;
        end
        do_reset();
    endtask

    task automatic test_count_zero();
        logic [7:0] b;
        do_reset();
        do_start(13'd3, 8'd0);
        n_tests++;
        if (fetch_req !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL count0: fetch_req=%b busy=%b want 0/0",
                     fetch_req, busy);
            n_fail++;
        end
        next_byte(b);
        n_tests++;
        if (b !== 8'h00 || req_cnt !== 0) begin
            $display("FAIL count0_byte: byte=%h reqs=%0d want 00/0", b, req_cnt);
            n_fail++;
        end
    endtask

    task automatic test_single();
        logic [7:0] b;
        logic [7:0] exp;
        do_reset();
        fetch_lat = 3;
        do_start(13'd5, 8'd1);
        n_tests++;
        if (fetch_req !== 1'b1 || fetch_addr !== 13'd5 || busy !== 1'b1) begin
            $display("FAIL single_req: req=%b addr=%h busy=%b want 1/0005/1",
                     fetch_req, fetch_addr, busy);
            n_fail++;
        end
        for (int i = 0; i < 23; i++) begin
            next_byte(b);
            exp = (i >= 6 && i < 22) ? {4'h5, 4'(i - 6)} : 8'h00;
            n_tests++;
            if (b !== exp) begin
                $display("FAIL single_byte%0d: got %h want %h", i, b, exp);
                n_fail++;
            end
        end
        n_tests++;
        if (busy !== 1'b0 || underrun !== 1'b0) begin
            $display("FAIL single_end: busy=%b underrun=%b want 0/0",
                     busy, underrun);
            n_fail++;
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] b;
        logic [7:0] exp;
        do_reset();
        do_start(13'd5, 8'd3);
        for (int i = 0; i < 54; i++) begin
            next_byte(b);
            exp = (i < 6) ? 8'h00 : {4'(5 + (i - 6) / 16), 4'((i - 6) % 16)};
            n_tests++;
            if (b !== exp) begin
                $display("FAIL b2b_byte%0d: got %h want %h", i, b, exp);
                n_fail++;
            end
            if (i == 52) begin
                n_tests++;
                if (busy !== 1'b1) begin
                    $display("FAIL b2b_busy52: got %b want 1", busy);
                    n_fail++;
                end
            end
        end
        n_tests++;
        if (busy !== 1'b0 || underrun !== 1'b0) begin
            $display("FAIL b2b_end: busy=%b underrun=%b want 0/0", busy, underrun);
            n_fail++;
        end
        n_tests++;
        if (req_cnt !== 3 || req_addr[0] !== 13'd5 || req_addr[1] !== 13'd6 ||
            req_addr[2] !== 13'd7) begin
            $display("FAIL b2b_addrs: n=%0d a=%h,%h,%h want 3 5,6,7", req_cnt,
                     req_addr[0], req_addr[1], req_addr[2]);
            n_fail++;
        end
    endtask

    task automatic test_underrun();
        logic [7:0] b;
        logic [7:0] exp;
        do_reset();
        block_from = 1;
        do_start(13'd5, 8'd2);
        for (int i = 0; i < 22; i++) begin
            next_byte(b);
            exp = (i < 6) ? 8'h00 : {4'h5, 4'(i - 6)};
            n_tests++;
            if (b !== exp) begin
                $display("FAIL urun_byte%0d: got %h want %h", i, b, exp);
                n_fail++;
            end
        end
        next_byte(b);
        n_tests++;
        if (b !== 8'h00 || underrun !== 1'b1 || req_cnt !== 2) begin
            $display("FAIL urun_flag: byte=%h underrun=%b reqs=%0d want 00/1/2",
                     b, underrun, req_cnt);
            n_fail++;
        end
        release_fetch = 1'b1;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            next_byte(b);
            exp = {4'h6, 4'(i)};
            n_tests++;
            if (b !== exp) begin
                $display("FAIL urun_l1_byte%0d: got %h want %h", i, b, exp);
                n_fail++;
            end
        end
        n_tests++;
        if (busy !== 1'b0 || underrun !== 1'b1) begin
            $display("FAIL urun_end: busy=%b underrun=%b want 0/1", busy, underrun);
            n_fail++;
        end
    endtask

    task automatic test_addr_wrap();
        logic [7:0] b;
        do_reset();
        do_start(13'h1FFF, 8'd2);
        for (int i = 0; i < 7; i++) next_byte(b);
        n_tests++;
        if (b !== 8'hF0) begin
            $display("FAIL wrap_byte0: got %h want f0", b);
            n_fail++;
        end
        repeat (4) @(negedge clk);
        n_tests++;
        if (req_cnt !== 2 || req_addr[0] !== 13'h1FFF || req_addr[1] !== 13'h0) begin
            $display("FAIL wrap_addr: n=%0d a=%h,%h want 2 1fff,0000",
                     req_cnt, req_addr[0], req_addr[1]);
            n_fail++;
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] b;
        do_reset();
        auto_fetch = 1'b0;
        do_start(13'd5, 8'd2);
        fetch_done = 1'b1;
        label_in   = mk_label(13'd5);
        @(negedge clk);
        fetch_done = 1'b0;
        for (int i = 0; i < 9; i++) next_byte(b);
        n_tests++;
        if (b !== 8'h52 || busy !== 1'b1) begin
            $display("FAIL rstmid_pre: byte=%h busy=%b want 52/1", b, busy);
            n_fail++;
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        n_tests++;
        if (out_byte !== 8'h00 || {fetch_req, busy, underrun} !== 3'b000 ||
            fetch_addr !== 13'h0) begin
            $display("FAIL rstmid_async: byte=%h flags=%b addr=%h want 00/000/0000",
                     out_byte, {fetch_req, busy, underrun}, fetch_addr);
            n_fail++;
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        fetch_done = 1'b1;
        label_in   = mk_label(13'd6);
        @(negedge clk);
        fetch_done = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++;
        if (out_byte !== 8'h00 || {fetch_req, busy, underrun} !== 3'b000 ||
            fetch_addr !== 13'h0) begin
            $display("FAIL rstmid_late: byte=%h flags=%b addr=%h want 00/000/0000",
                     out_byte, {fetch_req, busy, underrun}, fetch_addr);
            n_fail++;
        end
        next_byte(b);
        n_tests++;
        if (b !== 8'h00 || busy !== 1'b0) begin
            $display("FAIL rstmid_idle: byte=%h busy=%b want 00/0", b, busy);
            n_fail++;
        end
    endtask

    task automatic test_start_abort();
        logic [7:0] b;
        do_reset();
        fetch_lat = 20;
        do_start(13'd5, 8'd1);
        for (int i = 0; i < 7; i++) next_byte(b);
        n_tests++;
        if (b !== 8'h00 || underrun !== 1'b1) begin
            $display("FAIL abort_urun: byte=%h underrun=%b want 00/1", b, underrun);
            n_fail++;
        end
        repeat (20) @(negedge clk);
        for (int i = 0; i < 3; i++) next_byte(b);
        n_tests++;
        if (b !== 8'h52) begin
            $display("FAIL abort_pre: got %h want 52", b);
            n_fail++;
        end
        fetch_lat  = 0;
        start      = 1'b1;
        start_addr = 13'd9;
        count      = 8'd1;
        out_next   = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        out_next = 1'b0;
        n_tests++;
        if (out_byte !== 8'h00 || fetch_req !== 1'b1 || fetch_addr !== 13'd9 ||
            underrun !== 1'b0 || busy !== 1'b1) begin
            $display("FAIL abort_start: byte=%h req=%b addr=%h urun=%b busy=%b want 00/1/0009/0/1",
                     out_byte, fetch_req, fetch_addr, underrun, busy);
            n_fail++;
        end
        for (int i = 0; i < 7; i++) next_byte(b);
        n_tests++;
        if (b !== 8'h90) begin
            $display("FAIL abort_new: got %h want 90", b);
            n_fail++;
        end
    endtask

    initial begin
        auto_fetch    = 1'b1;
        fetch_lat     = 0;
        block_from    = 255;
        release_fetch = 1'b0;
        req_cnt       = 0;
        test_reset();
        test_count_zero();
        test_single();
        test_back_to_back();
        test_underrun();
        test_addr_wrap();
        test_reset_mid();
        test_start_abort();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
